// File: rtl/vsim_send_arbiter.sv
// Four-requester round-robin arbiter that locks a grant for a whole message and
// feeds a one-entry output buffer toward the VsimSend port.
module vsim_send_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAXBEATS = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [3:0]         req_pend,
  input  logic [3:0]         req_enq__ENA,
  input  logic [4*WIDTH-1:0] req_enq_v,
  input  logic [3:0]         req_enq_last,
  output logic [3:0]         req_enq__RDY,
  output logic               send_enq__ENA,
  output logic [WIDTH-1:0]   send_enq_v,
  output logic               send_enq_last,
  input  logic               send_enq__RDY,
  output logic               busy,
  output logic [1:0]         owner,
  output logic [7:0]         trunc_count
);

  localparam int CW = $clog2(MAXBEATS) + 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [7:0]       trunc_q, trunc_d;

  logic [WIDTH-1:0] beat_v [4];
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic             lock_rdy;
  logic             accept;
  logic             owner_last;
  logic             forced;

  for (genvar gi = 0; gi < 4; gi++) begin : g_req
    assign beat_v[gi]       = req_enq_v[gi*WIDTH +: WIDTH];
    assign req_enq__RDY[gi] = (state_q == LOCKED) && (owner_q == 2'(gi)) && lock_rdy;
  end

  // Scan from the farthest offset down so the nearest pending requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (req_pend[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign lock_rdy   = !full_q || send_enq__RDY;
  assign accept     = (state_q == LOCKED) && req_enq__ENA[owner_q] && lock_rdy;
  assign owner_last = req_enq_last[owner_q];
  assign forced     = !owner_last && (beat_cnt_q == CW'(MAXBEATS - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    full_d     = full_q;
    data_d     = data_q;
    last_d     = last_q;
    trunc_d    = trunc_q;

    if (full_q && send_enq__RDY) begin
      full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          data_d     = beat_v[owner_q];
          last_d     = owner_last || forced;
          full_d     = 1'b1;
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (owner_last || forced) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + 2'd1;
          end
          if (forced && (trunc_q != 8'hFF)) begin
            trunc_d = trunc_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      full_q     <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      trunc_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      full_q     <= full_d;
      data_q     <= data_d;
      last_q     <= last_d;
      trunc_q    <= trunc_d;
    end
  end

  assign send_enq__ENA = full_q;
  assign send_enq_v    = data_q;
  assign send_enq_last = last_q;
  assign busy          = (state_q == LOCKED);
  assign owner         = owner_q;
  assign trunc_count   = trunc_q;

endmodule

// File: tb/tb_vsim_send_arbiter.sv
// Scoreboard bench for vsim_send_arbiter: accepted beats are queued with their
// expected last flag and compared against the downstream stream.
module tb_vsim_send_arbiter;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [3:0]   req_pend;
  logic [3:0]   req_enq__ENA;
  logic [4*W-1:0] req_enq_v;
  logic [3:0]   req_enq_last;
  logic [3:0]   req_enq__RDY;
  logic         send_enq__ENA;
  logic [W-1:0] send_enq_v;
  logic         send_enq_last;
  logic         send_enq__RDY;
  logic         busy;
  logic [1:0]   owner;
  logic [7:0]   trunc_count;

  logic         pend_a [4];
  logic         ena_a  [4];
  logic [W-1:0] dat_a  [4];
  logic         last_a [4];
  logic         send_rdy = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cnt [4];
  int msg_beats [4];
  logic [W:0] sb [$];
  int out_cyc [$];
  int grant_log [$];
  int gap_log [$];
  logic prev_busy = 1'b0;
  int idle_run = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_pend[i]            = pend_a[i];
      req_enq__ENA[i]        = ena_a[i];
      req_enq_last[i]        = last_a[i];
      req_enq_v[i*W +: W]    = dat_a[i];
    end
    send_enq__RDY = send_rdy;
  end

  vsim_send_arbiter #(.WIDTH(W), .MAXBEATS(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_pend(req_pend), .req_enq__ENA(req_enq__ENA), .req_enq_v(req_enq_v),
    .req_enq_last(req_enq_last), .req_enq__RDY(req_enq__RDY),
    .send_enq__ENA(send_enq__ENA), .send_enq_v(send_enq_v), .send_enq_last(send_enq_last),
    .send_enq__RDY(send_enq__RDY), .busy(busy), .owner(owner), .trunc_count(trunc_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are judged on the negedge, where inputs and RDY are settled
  // for the upcoming rising edge.
  always @(negedge CLK) begin
    logic [W:0] e;
    logic       exp_last;
    cyc++;
    if (!nRST) begin
      prev_busy = 1'b0;
      idle_run  = 0;
    end else begin
      if (send_enq__ENA && send_enq__RDY) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(send_enq_v), 64'(e[W-1:0]));
          check("out_last", 64'(send_enq_last), 64'(e[W]));
        end
        out_cyc.push_back(cyc);
        $display("beat out data=%08h last=%0d owner=%0d", send_enq_v, send_enq_last, owner);
      end
      for (int i = 0; i < 4; i++) begin
        if (req_enq__ENA[i] && req_enq__RDY[i]) begin
          exp_last = req_enq_last[i] || (msg_beats[i] == 15);
          sb.push_back({exp_last, req_enq_v[i*W +: W]});
          msg_beats[i] = exp_last ? 0 : msg_beats[i] + 1;
          acc_cnt[i]++;
        end
      end
      check("rdy_onehot", 64'($countones(req_enq__RDY) <= 1), 64'd1);
      if (busy && !prev_busy) begin
        grant_log.push_back(int'(owner));
        gap_log.push_back(idle_run);
        idle_run = 0;
      end else if (!busy) begin
        idle_run++;
      end
      prev_busy = busy;
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_msg(input int i, input int n, input logic [W-1:0] base, input bit has_last);
    int s;
    int to;
    pend_a[i] = 1'b1;
    for (int b = 0; b < n; b++) begin
      ena_a[i]  = 1'b1;
      dat_a[i]  = base + W'(b);
      last_a[i] = has_last && (b == n - 1);
      s  = acc_cnt[i];
      to = 0;
      while (acc_cnt[i] == s && to < 300) begin
        @(posedge CLK);
        #1;
        to++;
      end
      check("drv_timeout", 64'(to < 300), 64'd1);
    end
    ena_a[i]  = 1'b0;
    last_a[i] = 1'b0;
    pend_a[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int to;
    logic [W-1:0] held;
    for (int i = 0; i < 4; i++) begin
      pend_a[i] = 0; ena_a[i] = 0; dat_a[i] = '0; last_a[i] = 0;
      acc_cnt[i] = 0; msg_beats[i] = 0;
    end
    #23;
    check("rst_ena",   64'(send_enq__ENA), 64'd0);
    check("rst_v",     64'(send_enq_v),    64'd0);
    check("rst_last",  64'(send_enq_last), 64'd0);
    check("rst_busy",  64'(busy),          64'd0);
    check("rst_owner", 64'(owner),         64'd0);
    check("rst_trunc", 64'(trunc_count),   64'd0);
    check("rst_rdy",   64'(req_enq__RDY),  64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    settle(2);

    // Round-robin with all four pending; requester 0 comes back for a second turn.
    grant_log.delete(); gap_log.delete();
    fork
      begin send_msg(0, 1, 32'h100, 1); send_msg(0, 1, 32'h104, 1); end
      send_msg(1, 1, 32'h110, 1);
      send_msg(2, 1, 32'h120, 1);
      send_msg(3, 1, 32'h130, 1);
    join
    settle(3);
    check("rr_len", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check($sformatf("rr_owner%0d", k), 64'(grant_log[k]), 64'(k % 4));
    for (int k = 1; k < 5 && k < gap_log.size(); k++)
      check($sformatf("rr_gap%0d", k), 64'(gap_log[k]), 64'd1);

    // Single three-beat message from requester 0.
    out_cyc.delete();
    fork
      send_msg(0, 3, 32'hA0, 1);
      begin
        @(negedge CLK); check("lat_rdy0_pre",  64'(req_enq__RDY[0]), 64'd0);
        @(negedge CLK); check("lat_rdy0_post", 64'(req_enq__RDY[0]), 64'd1);
      end
    join
    settle(3);
    check("single_busy", 64'(busy), 64'd0);
    check("single_nout", 64'(out_cyc.size()), 64'd3);
    if (out_cyc.size() == 3) begin
      check("single_b2b_1", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
      check("single_b2b_2", 64'(out_cyc[2] - out_cyc[1]), 64'd1);
    end

    // Backpressure; rr_ptr is now 1, so requester 1 is granted before 0.
    grant_log.delete();
    fork
      send_msg(1, 4, 32'hB0, 1);
      send_msg(0, 1, 32'hC0, 1);
      begin
        to = 0;
        do begin @(negedge CLK); to++; end while (!send_enq__ENA && to < 50);
        check("bp_wait", 64'(to < 50), 64'd1);
        @(posedge CLK); #1;
        send_rdy = 1'b0;
        @(negedge CLK);
        held = send_enq_v;
        for (int k = 0; k < 5; k++) begin
          check("bp_rdy",  64'(req_enq__RDY), 64'd0);
          check("bp_ena",  64'(send_enq__ENA), 64'd1);
          check("bp_hold", 64'(send_enq_v), 64'(held));
          @(negedge CLK);
        end
        @(posedge CLK); #1;
        send_rdy = 1'b1;
      end
    join
    settle(3);
    check("bp_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check("bp_first",  64'(grant_log[0]), 64'd1);
      check("bp_second", 64'(grant_log[1]), 64'd0);
    end

    // Truncation: requester 2 streams 20 beats without last; requester 3 waits.
    grant_log.delete();
    s = acc_cnt[2];
    fork
      send_msg(2, 20, 32'h200, 0);
      begin
        to = 0;
        while (acc_cnt[2] - s < 14 && to < 300) begin @(posedge CLK); #1; to++; end
        check("tr_wait", 64'(to < 300), 64'd1);
        send_msg(3, 1, 32'h300, 1);
      end
    join
    send_msg(2, 1, 32'h2FF, 1);
    settle(3);
    check("tr_count", 64'(trunc_count), 64'd1);
    check("tr_grants", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() >= 3) begin
      check("tr_g0", 64'(grant_log[0]), 64'd2);
      check("tr_g1", 64'(grant_log[1]), 64'd3);
      check("tr_g2", 64'(grant_log[2]), 64'd2);
    end

    // Non-owner requester 3 raises ENA during requester 1's grant.
    fork
      send_msg(1, 3, 32'h1A0, 1);
      begin
        ena_a[3] = 1'b1; dat_a[3] = 32'hDEAD;
        for (int k = 0; k < 6; k++) begin
          @(negedge CLK);
          check("ill_rdy3", 64'(req_enq__RDY[3]), 64'd0);
        end
        ena_a[3] = 1'b0; dat_a[3] = '0;
      end
    join
    settle(3);

    // Reset after two of four beats.
    pend_a[2] = 1'b1; ena_a[2] = 1'b1; dat_a[2] = 32'hD0;
    s = acc_cnt[2]; to = 0;
    while (acc_cnt[2] - s < 2 && to < 50) begin
      @(posedge CLK); #1; to++;
      dat_a[2] = 32'hD0 + W'(acc_cnt[2] - s);
    end
    check("mr_wait", 64'(to < 50), 64'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("mr_ena",   64'(send_enq__ENA), 64'd0);
    check("mr_v",     64'(send_enq_v),    64'd0);
    check("mr_last",  64'(send_enq_last), 64'd0);
    check("mr_busy",  64'(busy),          64'd0);
    check("mr_owner", 64'(owner),         64'd0);
    check("mr_trunc", 64'(trunc_count),   64'd0);
    check("mr_rdy",   64'(req_enq__RDY),  64'd0);
    pend_a[2] = 1'b0; ena_a[2] = 1'b0; dat_a[2] = '0;
    sb.delete();
    for (int i = 0; i < 4; i++) msg_beats[i] = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("mr_quiet", 64'(send_enq__ENA), 64'd0);
    end
    grant_log.delete();
    @(posedge CLK); #1;
    send_msg(3, 2, 32'hE0, 1);
    settle(3);
    check("mr_regrant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd3);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vsim_send_arbiter.md
VSIM_SEND_ARBITER -- requirements
Module: vsim_send_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, beat data width; MAXBEATS, default 16, maximum beats per message before forced termination.
REQ-002 Clocking SHALL be one clock and one reset; nRST is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 req_pend  in  4  per-requester "message waiting" flag, bit i = requester i.
REQ-006 req_enq__ENA  in  4  per-requester beat enable.
REQ-007 req_enq_v  in  4*WIDTH  per-requester beat data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_enq_last  in  4  per-requester final-beat marker.
REQ-009 req_enq__RDY  out  4  per-requester beat ready.
REQ-010 send_enq__ENA  out  1  downstream beat valid, driven directly from the output buffer full flag.
REQ-011 send_enq_v  out  WIDTH  downstream beat data.
REQ-012 send_enq_last  out  1  downstream final-beat marker.
REQ-013 send_enq__RDY  in  1  downstream ready, the VsimSend port ready.
REQ-014 busy  out  1  high while in the LOCKED state.
REQ-015 owner  out  2  index of the current or most recent grant holder.
REQ-016 trunc_count  out  8  count of forced message terminations; saturates at 255.

Function
REQ-017 The FSM SHALL have two states, IDLE and LOCKED, and SHALL hold a round-robin pointer rr_ptr (2 bits).
REQ-018 In IDLE, all req_enq__RDY SHALL be 0.
REQ-019 In IDLE with any req_pend bit set, the block SHALL select the first set bit searching rr_ptr, rr_ptr+1, ... (mod 4), load it into owner, clear beat_cnt, and enter LOCKED on the next edge.
REQ-020 In IDLE with req_pend == 0, the state SHALL remain unchanged.
REQ-021 In LOCKED, req_enq__RDY[owner] SHALL equal (!full || send_enq__RDY), and all other RDY bits SHALL be 0.
REQ-022 A beat SHALL be accepted only when req_enq__ENA[owner] && req_enq__RDY[owner].
REQ-023 An ENA without RDY, or an ENA from a non-owner, SHALL be ignored with no state change.
REQ-024 An accepted beat SHALL be loaded into the one-entry output buffer: data, last, and full=1.
REQ-025 The loaded beat SHALL appear on send_* one cycle after acceptance.
REQ-026 The buffer SHALL drain when full && send_enq__RDY; full SHALL clear unless a new beat loads in the same cycle.
REQ-027 Simultaneous drain and load SHALL sustain 1 beat/cycle.
REQ-028 Each accepted beat SHALL increment beat_cnt (width clog2(MAXBEATS)+1).
REQ-029 An accepted beat with last=1 SHALL return the FSM to IDLE and set rr_ptr = owner+1 mod 4.
REQ-030 An accepted beat with last=0 while beat_cnt == MAXBEATS-1 SHALL be forced to last=1 in the buffer, return the FSM to IDLE, advance rr_ptr as in REQ-029, and increment trunc_count, saturating at 255.
REQ-031 After a forced termination, the requester's subsequent beats SHALL be treated as a new message requiring re-arbitration.
REQ-032 Exactly one IDLE cycle SHALL separate consecutive messages; the arbitration latency from req_pend to first RDY is one cycle.
REQ-033 A req_pend deassertion while LOCKED SHALL have no effect; the grant persists until a last or forced beat.
REQ-034 A full buffer SHALL be held stable while send_enq__RDY=0; data and last SHALL not change until drained.

Reset
REQ-035 nRST=0 SHALL asynchronously force: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, full 0, send_enq_v 0, send_enq_last 0, trunc_count 0, busy 0, req_enq__RDY 0.
REQ-036 Reset asserted mid-message SHALL discard the buffered beat and in-progress message without emitting them.
REQ-037 After nRST deasserts, the first arbitration SHALL occur on the first edge with any req_pend bit set.

Verification
REQ-038 Single message: req_pend=0001, 3 beats 0xA0..0xA2 with last on 0xA2, send_enq__RDY=1 -> RDY[0] rises 1 cycle after pend; send_* emits 0xA0,0xA1,0xA2 on consecutive cycles, last only on 0xA2; busy falls after the last beat; rr_ptr=1.
REQ-039 Round-robin fairness: req_pend=1111 held, each requester sends 1-beat messages -> owner sequence 0,1,2,3,0 with one IDLE cycle between grants.
REQ-040 Backpressure: send_enq__RDY=0 for 5 cycles with the buffer full -> RDY[owner]=0; send_enq_v is held constant; no beat is lost or duplicated when RDY returns.
REQ-041 Truncation: MAXBEATS=16, requester 2 sends 20 beats with no last -> beat 16 emitted with send_enq_last=1; trunc_count=1; grant moves to the next pending requester.
REQ-042 Reset mid-message: nRST pulsed low after 2 of 4 beats -> all outputs reach reset values immediately; no further send_enq__ENA until re-arbitration.
REQ-043 Illegal ENA: non-owner requester 3 asserts ENA during requester 1's grant -> ignored; the output stream contains only requester 1's data.
